// File: rtl/mips_hazard_ctrl_if.sv
// D-stage request and hazard-control bundle between the MIPS pipeline (master)
// and the hazard/forwarding controller (slave).
interface mips_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2
);
    logic                          d_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] d_src;
    logic [NUM_SRC-1:0]            d_src_used;
    logic [REG_ADDR_W-1:0]         d_dst;
    logic                          d_regwrite;
    logic                          d_memread;
    logic                          redirect_x;

    logic                          stall_f;
    logic                          stall_d;
    logic                          bubble_x;
    logic                          flush_d;
    logic [2*NUM_SRC-1:0]          fwd_sel;
    logic [NUM_SRC-1:0]            byp_d;

    modport master (
        output d_valid, d_src, d_src_used, d_dst, d_regwrite, d_memread, redirect_x,
        input  stall_f, stall_d, bubble_x, flush_d, fwd_sel, byp_d
    );

    modport slave (
        input  d_valid, d_src, d_src_used, d_dst, d_regwrite, d_memread, redirect_x,
        output stall_f, stall_d, bubble_x, flush_d, fwd_sel, byp_d
    );
endinterface

// File: rtl/mips_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS core: shadows X/M/W destination
// info, detects RAW hazards on the D-stage instruction and drives stall/flush/forward controls.
module mips_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_hazard_ctrl_if.slave    hz,
    input  logic                 clr_cnt,
    output logic                 x_valid,
    output logic                 m_valid,
    output logic                 w_valid,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    typedef struct packed {
        logic                          valid;
        logic [REG_ADDR_W-1:0]         dst;
        logic                          regwrite;
        logic                          memread;
        logic [NUM_SRC*REG_ADDR_W-1:0] src;
        logic [NUM_SRC-1:0]            src_used;
    } ent_t;

    ent_t x_q, x_d;
    ent_t m_q, m_d;
    ent_t w_q, w_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic                 haz;
    logic                 stall;
    logic [2*NUM_SRC-1:0] fwd_sel_c;
    logic [NUM_SRC-1:0]   byp_c;

    // Register 0 is hard-wired to zero, so it never carries a dependency.
    function automatic logic producer_match(input ent_t p,
                                            input logic [REG_ADDR_W-1:0] op,
                                            input logic used);
        return p.valid && p.regwrite && (p.dst != '0) && used && (p.dst == op);
    endfunction

    always_comb begin
        logic [REG_ADDR_W-1:0] d_op;
        logic [REG_ADDR_W-1:0] x_op;
        logic                  d_use;
        logic                  x_use;
        haz       = 1'b0;
        fwd_sel_c = '0;
        byp_c     = '0;
        d_op      = '0;
        x_op      = '0;
        d_use     = 1'b0;
        x_use     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            d_op  = hz.d_src[i*REG_ADDR_W +: REG_ADDR_W];
            d_use = hz.d_src_used[i];
            x_op  = x_q.src[i*REG_ADDR_W +: REG_ADDR_W];
            x_use = x_q.src_used[i] && x_q.valid;
            if (FWD_EN != 0) begin
                if (producer_match(x_q, d_op, d_use) && x_q.memread) begin
                    haz = 1'b1;
                end
                // The regfile write in W lands at the edge, too late for this D read.
                if (producer_match(w_q, d_op, d_use)) begin
                    byp_c[i] = 1'b1;
                end
                if (producer_match(m_q, x_op, x_use)) begin
                    fwd_sel_c[2*i +: 2] = 2'b01;
                end else if (producer_match(w_q, x_op, x_use)) begin
                    fwd_sel_c[2*i +: 2] = 2'b10;
                end
            end else begin
                if (producer_match(x_q, d_op, d_use) ||
                    producer_match(m_q, d_op, d_use) ||
                    producer_match(w_q, d_op, d_use)) begin
                    haz = 1'b1;
                end
            end
        end
    end

    // A redirect discards the D instruction, so it overrides any stall request.
    assign stall = haz && hz.d_valid && !hz.redirect_x;

    assign hz.stall_f  = stall;
    assign hz.stall_d  = stall;
    assign hz.bubble_x = stall || hz.redirect_x;
    assign hz.flush_d  = hz.redirect_x;
    assign hz.fwd_sel  = fwd_sel_c;
    assign hz.byp_d    = byp_c;

    always_comb begin
        w_d = m_q;
        m_d = x_q;
        x_d = '0;
        if (!(stall || hz.redirect_x)) begin
            x_d.valid    = hz.d_valid;
            x_d.dst      = hz.d_dst;
            x_d.regwrite = hz.d_regwrite;
            x_d.memread  = hz.d_memread;
            x_d.src      = hz.d_src;
            x_d.src_used = hz.d_src_used;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (hz.redirect_x && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            x_q         <= x_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign x_valid   = x_q.valid;
    assign m_valid   = m_q.valid;
    assign w_valid   = w_q.valid;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
